// File: rtl/klein_pkg.sv
// Shared KLEIN definitions: S-box table, iterative-layer FSM states and
// a configuration legality check used by the substitution layers.
package klein_pkg;

    // FSM states for iterative KLEIN layers
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // KLEIN 4-bit S-box packed as a table; nibble k holds SBOX(k).
    // 0..F -> 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5 (an involution)
    localparam logic [63:0] SBOX_TABLE = 64'h5DE8_623C_0BF1_9A47;

    // S-box lookup
    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    // Width must be whole nibbles, and the lane count must tile the nibbles
    function automatic bit legal_cfg(input int data_w, input int lanes);
        return (data_w >= 4) && ((data_w % 4) == 0) && (lanes >= 1)
            && (((data_w / 4) % lanes) == 0);
    endfunction

endpackage

// File: rtl/sub_nibbles_iter_if.sv
// Valid/ready handshake bundle for the iterative nibble-substitution layer.
interface sub_nibbles_iter_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] in_data;
    logic              in_bypass;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Block side: consumes the input request, produces the result
    modport slave (
        input  in_data, in_bypass, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    // Producer/consumer side
    modport master (
        output in_data, in_bypass, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/klein_sbox.sv
// Single KLEIN S-box, purely combinational; shared by every KLEIN layer.
module klein_sbox
    import klein_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);
    assign y = sbox(x);
endmodule

// File: rtl/sub_nibbles_iter.sv
// Iterative KLEIN substitution layer: LANES S-boxes per clock, the state
// register rotating right by one lane group per pass, so after N passes
// every nibble is back in its own position, substituted in place.
module sub_nibbles_iter
    import klein_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sub_nibbles_iter_if.slave bus
);
    localparam int LW    = 4 * LANES;
    localparam int N     = DATA_W / LW;
    localparam int CNT_W = ($clog2(N + 1) > 1) ? $clog2(N + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (!legal_cfg(DATA_W, LANES)) begin : g_cfg_err
        $error("sub_nibbles_iter: LANES must divide DATA_W/4, DATA_W a multiple of 4");
    end

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       sreg;
    logic                    byp;
    logic [LANES-1:0][3:0]   sub;
    logic [LW-1:0]           lane_out;
    logic [DATA_W-1:0]       rot;
    logic                    accept;

    // One S-box per lane, always looking at the low lane group
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        klein_sbox u_sbox (
            .x (sreg[4*l +: 4]),
            .y (sub[l])
        );
    end

    assign lane_out = byp ? sreg[LW-1:0] : sub;

    // Processed group re-enters at the top; single-pass case has nothing to rotate
    if (LW == DATA_W) begin : g_full
        assign rot = lane_out;
    end else begin : g_rot
        assign rot = {lane_out, sreg[DATA_W-1:LW]};
    end

    assign accept = bus.in_valid && (state == IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: last pass lands in DONE; drain blocks a same-edge accept
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshakes are pure state decodes
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Datapath: load on accept, one lane group per RUN cycle, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            byp  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= bus.in_data;
            byp  <= bus.in_bypass;
            cnt  <= '0;
        end else if (state == RUN) begin
            sreg <= rot;
            cnt  <= cnt + 1'b1;
        end
    end

    // Result comes straight off the state register
    assign bus.out_data = sreg;

endmodule

// File: tb/tb_sub_nibbles_iter.sv
// Bench for sub_nibbles_iter: behavioural model + per-cycle compare on the
// LANES=4 instance, directed literal vectors, and latency checks at LANES=16/1.
module tb_sub_nibbles_iter;
    localparam int NM = 4;   // passes at DATA_W=64, LANES=4

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    sub_nibbles_iter_if #(.DATA_W(64)) bm ();
    sub_nibbles_iter_if #(.DATA_W(64)) b16 ();
    sub_nibbles_iter_if #(.DATA_W(64)) b1 ();

    sub_nibbles_iter #(.DATA_W(64), .LANES(4))  dut   (.clk(clk), .rst_n(rst_n), .bus(bm));
    sub_nibbles_iter #(.DATA_W(64), .LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    sub_nibbles_iter #(.DATA_W(64), .LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));

    logic [63:0] x_data = '0;
    logic        x_byp = 1'b0, x_valid = 1'b0, x_ready = 1'b0;
    assign b16.in_data = x_data;  assign b16.in_bypass = x_byp;
    assign b16.in_valid = x_valid; assign b16.out_ready = x_ready;
    assign b1.in_data = x_data;   assign b1.in_bypass = x_byp;
    assign b1.in_valid = x_valid;  assign b1.out_ready = x_ready;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Whole-block substitution straight from the S-box definition
    function automatic logic [63:0] exp_fn(input logic [63:0] d, input logic b);
        int sb [16] = '{7, 4, 10, 9, 1, 15, 11, 0, 12, 3, 2, 6, 8, 14, 13, 5};
        logic [63:0] r = d;
        if (!b)
            for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'(sb[d[4*i +: 4]]);
        return r;
    endfunction

    // Model: idle / busy for NM cycles / done until drained
    int          m_phase = 0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_res <= '0;
        end else begin
            case (m_phase)
                0: if (bm.in_valid) begin
                       m_res <= exp_fn(bm.in_data, bm.in_bypass);
                       m_left <= NM; m_phase <= 1;
                   end
                1: begin
                       if (m_left == 1) m_phase <= 2;
                       m_left <= m_left - 1;
                   end
                default: if (bm.out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("cmp_rst_in_ready", 64'(bm.in_ready), 64'd1);
            chk("cmp_rst_out_valid", 64'(bm.out_valid), 64'd0);
            chk("cmp_rst_out_data", bm.out_data, 64'd0);
        end else begin
            chk("cmp_in_ready", 64'(bm.in_ready), 64'(m_phase == 0));
            chk("cmp_out_valid", 64'(bm.out_valid), 64'(m_phase == 2));
            if (m_phase == 2) chk("cmp_out_data", bm.out_data, m_res);
        end
    end

    // Accept one block on the main instance, measure latency, optionally drain
    task automatic run_vec(input string name, input logic [63:0] d, input logic b,
                           input logic [63:0] exp, input bit drain);
        int lat = 0;
        int w = 0;
        while (!bm.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        chk({name, "_in_ready"}, 64'(bm.in_ready), 64'd1);
        bm.in_data = d; bm.in_bypass = b; bm.in_valid = 1'b1;
        @(posedge clk); #1;
        bm.in_valid = 1'b0; bm.in_data = '0; bm.in_bypass = 1'b0;
        while (!bm.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({name, "_latency"}, 64'(lat), 64'(NM));
        chk({name, "_data"}, bm.out_data, exp);
        if (drain) begin
            bm.out_ready = 1'b1; @(posedge clk); #1; bm.out_ready = 1'b0;
        end
    endtask

    initial begin
        int l16, l1;
        logic [63:0] d16, d1;
        bm.in_data = '0; bm.in_bypass = 1'b0; bm.in_valid = 1'b0; bm.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bm.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bm.out_valid), 64'd0);
        chk("rst_out_data", bm.out_data, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_vec("vec_basic", 64'h0123456789ABCDEF, 1'b0, 64'h74A91FB0C3268ED5, 1'b1);
        run_vec("vec_bypass", 64'hDEADBEEF00C0FFEE, 1'b1, 64'hDEADBEEF00C0FFEE, 1'b1);
        run_vec("vec_zero", 64'h0, 1'b0, 64'h7777777777777777, 1'b1);
        run_vec("vec_ones", 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h5555555555555555, 1'b1);
        run_vec("vec_involution", 64'h74A91FB0C3268ED5, 1'b0, 64'h0123456789ABCDEF, 1'b1);

        // Backpressure: hold 10 cycles in DONE, stray input ignored
        run_vec("vec_bp", 64'h0123456789ABCDEF, 1'b0, 64'h74A91FB0C3268ED5, 1'b0);
        for (int c = 0; c < 10; c++) begin
            bm.in_valid = (c == 3); bm.in_data = 64'h1111111111111111;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(bm.out_valid), 64'd1);
            chk("bp_out_data", bm.out_data, 64'h74A91FB0C3268ED5);
            chk("bp_in_ready", 64'(bm.in_ready), 64'd0);
        end
        // Drain edge with in_valid high must not accept
        bm.in_valid = 1'b1; bm.out_ready = 1'b1;
        @(posedge clk); #1;
        bm.in_valid = 1'b0; bm.out_ready = 1'b0; bm.in_data = '0;
        chk("drain_no_accept", 64'(bm.in_ready), 64'd1);
        chk("drain_out_valid", 64'(bm.out_valid), 64'd0);

        // Reset during pass 2
        bm.in_data = 64'h0123456789ABCDEF; bm.in_valid = 1'b1;
        @(posedge clk); #1;
        bm.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_in_ready", 64'(bm.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bm.out_valid), 64'd0);
        chk("midrst_out_data", bm.out_data, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec("vec_after_rst", 64'h0123456789ABCDEF, 1'b0, 64'h74A91FB0C3268ED5, 1'b1);

        // LANES=16 and LANES=1 latency with the same stimulus
        l16 = -1; l1 = -1; d16 = '0; d1 = '0;
        x_data = 64'h0123456789ABCDEF; x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (b16.out_valid && l16 < 0) begin l16 = c; d16 = b16.out_data; end
            if (b1.out_valid && l1 < 0) begin l1 = c; d1 = b1.out_data; end
        end
        chk("l16_latency", 64'(l16), 64'd1);
        chk("l16_data", d16, 64'h74A91FB0C3268ED5);
        chk("l1_latency", 64'(l1), 64'd16);
        chk("l1_data", d1, 64'h74A91FB0C3268ED5);
        chk("l16_held", b16.out_data, 64'h74A91FB0C3268ED5);
        x_ready = 1'b1; @(posedge clk); #1; x_ready = 1'b0;
        chk("l16_drained", 64'(b16.in_ready), 64'd1);
        chk("l1_drained", 64'(b1.in_ready), 64'd1);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sub_nibbles_iter.md
SUB_NIBBLES_ITER -- requirements
Module: sub_nibbles_iter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning state width in bits; legal values are multiples of 4, at least 4.
REQ-002 SHALL have parameter LANES, default 4, meaning S-boxes applied per clock; legal values divide DATA_W/4 exactly.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, DATA_W bits: block to be substituted.
REQ-006 SHALL have port in_bypass, input, 1 bit: when 1 at acceptance, the block passes unsubstituted.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data and in_bypass are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept input.
REQ-009 SHALL have port out_data, output, DATA_W bits: result block.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.

Function
REQ-012 SHALL implement the KLEIN 4-bit S-box, 0..F -> 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5, an involution.
REQ-013 SHALL use N = DATA_W/(4*LANES) processing passes per block.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL assert in_ready exactly when state is IDLE; out_valid exactly when state is DONE.
REQ-016 SHALL accept on a rising edge with in_valid and in_ready both 1: load in_data into state register, latch in_bypass, clear pass counter, go to RUN.
REQ-017 SHALL, on each RUN edge, substitute the LANES least-significant nibbles (or pass them unchanged when bypass is latched), rotate the register right by 4*LANES bits with those nibbles entering at the top, and increment the counter.
REQ-018 SHALL go RUN -> DONE on the edge completing pass N, so out_valid rises exactly N cycles after the acceptance edge.
REQ-019 SHALL produce out_data with nibble i equal to SBOX(in_data nibble i) for all i, matching the order of the 16-S-box combinational layer at DATA_W=64.
REQ-020 SHALL hold out_data and out_valid stable in DONE while out_ready is 0 (backpressure, no data loss).
REQ-021 SHALL go DONE -> IDLE on an edge with out_ready=1; it does not accept input on that same edge (throughput one block per N+2 cycles minimum).
REQ-022 SHALL ignore in_valid, in_data and in_bypass while not IDLE.
REQ-023 SHALL size the pass counter at max(1, clog2(N+1)) bits; it does not wrap within a block.
REQ-024 SHALL, when N=1, complete in one RUN cycle with identical handshake behaviour.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, counter 0, state register 0, latched bypass 0, giving in_ready=1, out_valid=0, out_data=0.
REQ-026 SHALL, on rst_n assertion mid-RUN or mid-DONE, abandon the block with no partial output; after release, the first edge with in_valid=1 is a fresh acceptance.

Structure
REQ-027 SHALL take the S-box table, the FSM state enumeration and a DATA_W/LANES legality check function from shared package klein_pkg.
REQ-028 SHALL instantiate LANES copies of sub-module klein_sbox (4-bit combinational lookup), reusable by other KLEIN layers.
REQ-029 SHALL keep out_data driven directly from the state register, with no combinational path from in_data to out_data.

Verification
REQ-030 SHALL cover, at DATA_W=64 and LANES=4: in_data 0x0123456789ABCDEF with bypass 0 -> out_valid exactly 4 cycles after acceptance, out_data 0x74A91FB0C3268ED5.
REQ-031 SHALL cover, at DATA_W=64 and LANES=16: the same stimulus -> out_valid 1 cycle after acceptance with the same out_data; at LANES=1, 16 cycles.
REQ-032 SHALL cover bypass=1 with 0xDEADBEEF00C0FFEE -> out_data 0xDEADBEEF00C0FFEE with unchanged latency.
REQ-033 SHALL cover out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready 0, and a new in_valid pulse ignored.
REQ-034 SHALL cover the involution: feed out_data 0x74A91FB0C3268ED5 back -> 0x0123456789ABCDEF.
REQ-035 SHALL cover rst_n pulsed low during pass 2 -> outputs at reset values immediately; the next accepted block yields the correct result.
